// File: rtl/dot_product_accumulator.sv
// Dot-product engine: two skew FIFOs, a registered multiply stage and an accumulate/result stage.
// Optional build macro DOT_PRODUCT_SATURATE_EN makes the accumulator add saturate instead of wrap.

module dot_product_skew_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             push_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A same-cycle pop frees the slot, so a push on full is only dropped without one.
  assign push_ok = push && (!full || pop);

  // NOTE: the storage array carries no reset; only pointers and count define
  // which entries are live, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
      if (push && full && !pop) ovf <= 1'b1;
    end
  end
endmodule

module dot_product_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int VECTOR_LEN = 8,
  parameter int ACC_WIDTH  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic                  b_valid_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic [ACC_WIDTH-1:0]  result_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic                  a_ovf_o,
  output logic                  b_ovf_o,
  output logic                  busy_o
);
  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int CNT_WIDTH  = $clog2(VECTOR_LEN);

  logic                         a_empty;
  logic                         b_empty;
  logic [DATA_WIDTH-1:0]        a_head;
  logic [DATA_WIDTH-1:0]        b_head;
  logic                         stall;
  logic                         pop;
  logic                         fire;

  logic [CNT_WIDTH-1:0]         elem_cnt;
  logic                         cnt_last;
  logic signed [PROD_WIDTH-1:0] prod_c;
  logic signed [PROD_WIDTH-1:0] p_prod;
  logic                         p_valid;
  logic                         p_last;

  logic                         mid;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  acc_base;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [ACC_WIDTH-1:0]  acc_next;

  dot_product_skew_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_a_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (a_valid_i),
    .push_data (a_data_i),
    .pop       (pop),
    .head      (a_head),
    .empty     (a_empty),
    .ovf       (a_ovf_o)
  );

  dot_product_skew_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_b_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (b_valid_i),
    .push_data (b_data_i),
    .pop       (pop),
    .head      (b_head),
    .empty     (b_empty),
    .ovf       (b_ovf_o)
  );

  // Only a finished sum waiting on an unaccepted result blocks the pipeline.
  assign stall    = p_valid && p_last && result_valid_o && !result_ready_i;
  assign pop      = !a_empty && !b_empty && !stall;
  assign fire     = p_valid && !stall;
  assign cnt_last = (elem_cnt == CNT_WIDTH'(VECTOR_LEN - 1));

  assign prod_c   = PROD_WIDTH'($signed(a_head)) * PROD_WIDTH'($signed(b_head));
  assign prod_ext = ACC_WIDTH'(p_prod);

  assign busy_o   = !a_empty || !b_empty || p_valid || mid;

  // NOTE: every combinational output gets a default before any conditional
  // override, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_base = mid ? acc : '0;
    acc_sum  = acc_base + prod_ext;
    acc_next = acc_sum;
`ifdef DOT_PRODUCT_SATURATE_EN
    // Like-signed operands producing an opposite-signed sum is a signed overflow.
    if ((acc_base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
        (acc_sum[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1])) begin
      acc_next = acc_base[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      elem_cnt <= '0;
      p_valid  <= 1'b0;
      p_last   <= 1'b0;
      p_prod   <= '0;
    end else if (!stall) begin
      p_valid <= pop;
      if (pop) begin
        p_prod   <= prod_c;
        p_last   <= cnt_last;
        elem_cnt <= cnt_last ? '0 : elem_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mid            <= 1'b0;
      acc            <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
    end else begin
      if (fire) begin
        acc <= acc_next;
        mid <= !p_last;
      end
      // A new sum loading on the accept edge keeps valid high with fresh data.
      if (fire && p_last) begin
        result_o       <= acc_next;
        result_valid_o <= 1'b1;
      end else if (result_valid_o && result_ready_i) begin
        result_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator: cycle-exact result timing, skew, signed data,
// backpressure, FIFO overflow with reset recovery, and wrap/saturate behaviour.

module tb_dot_product_accumulator;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid_i;
  logic [31:0] a_data_i;
  logic        b_valid_i;
  logic [31:0] b_data_i;
  logic [63:0] result_o;
  logic        result_valid_o;
  logic        result_ready_i;
  logic        a_ovf_o;
  logic        b_ovf_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] a_vec [8];
  logic [31:0] b_vec [8];

  always #5 clk = ~clk;

  dot_product_accumulator dut (
    .clk            (clk),
    .reset          (reset),
    .a_valid_i      (a_valid_i),
    .a_data_i       (a_data_i),
    .b_valid_i      (b_valid_i),
    .b_data_i       (b_data_i),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .a_ovf_o        (a_ovf_o),
    .b_ovf_o        (b_ovf_o),
    .busy_o         (busy_o)
  );

  // Leaves the bench just after a rising edge, at the start of cycle 0.
  task automatic apply_reset();
    reset          = 1'b1;
    a_valid_i      = 1'b0;
    a_data_i       = '0;
    b_valid_i      = 1'b0;
    b_data_i       = '0;
    result_ready_i = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Streams a_vec from cycle a_off and b_vec from cycle b_off with ready held high.
  task automatic run_stream(input string name, input int a_off, input int b_off,
                            input int exp_cyc, input logic [63:0] exp);
    for (int c = 0; c <= exp_cyc + 1; c++) begin
      a_valid_i = 1'b0;
      a_data_i  = '0;
      b_valid_i = 1'b0;
      b_data_i  = '0;
      if (c >= a_off && c < a_off + 8) begin
        a_valid_i = 1'b1;
        a_data_i  = a_vec[c - a_off];
      end
      if (c >= b_off && c < b_off + 8) begin
        b_valid_i = 1'b1;
        b_data_i  = b_vec[c - b_off];
      end
      @(negedge clk);
      n_checks++;
      if (result_valid_o !== (c == exp_cyc)) begin
        n_fail++;
        $display("FAIL %s valid cycle %0d: got %b expected %b", name, c, result_valid_o, c == exp_cyc);
      end
      if (c == exp_cyc) begin
        n_checks++;
        if (result_o !== exp) begin
          n_fail++;
          $display("FAIL %s result: got %h expected %h", name, result_o, exp);
        end
      end
      if (c == exp_cyc + 1) begin
        n_checks++;
        if (busy_o !== 1'b0) begin
          n_fail++;
          $display("FAIL %s busy after result: got %b expected 0", name, busy_o);
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if ({a_ovf_o, b_ovf_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s ovf flags: got %b expected 00", name, {a_ovf_o, b_ovf_o});
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_checks++;
    if ({result_o, result_valid_o, a_ovf_o, b_ovf_o, busy_o} !== 68'd0) begin
      n_fail++;
      $display("FAIL reset values: got result=%h valid=%b aovf=%b bovf=%b busy=%b expected all 0",
               result_o, result_valid_o, a_ovf_o, b_ovf_o, busy_o);
    end
  endtask

  task automatic test_aligned();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      a_vec[i] = 32'(i + 1);
      b_vec[i] = 32'd2;
    end
    run_stream("aligned", 0, 0, 10, 64'd72);
  endtask

  task automatic test_skewed();
    apply_reset();
    run_stream("skewed", 0, 3, 13, 64'd72);
  endtask

  task automatic test_signed();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      a_vec[i] = -32'sd3;
      b_vec[i] = 32'd5;
    end
    run_stream("signed", 0, 0, 10, 64'hFFFF_FFFF_FFFF_FF88);
  endtask

  task automatic test_back_to_back();
    logic        exp_v;
    logic [63:0] exp_r;
    apply_reset();
    for (int c = 0; c <= 22; c++) begin
      a_valid_i      = (c < 16);
      a_data_i       = (c < 16) ? 32'((c % 8) + 1) : '0;
      b_valid_i      = (c < 16);
      b_data_i       = (c < 8) ? 32'd2 : ((c < 16) ? 32'd1 : 32'd0);
      result_ready_i = (c >= 20);
      exp_v = (c >= 10 && c <= 21);
      exp_r = (c == 21) ? 64'd36 : 64'd72;
      @(negedge clk);
      n_checks++;
      if (result_valid_o !== exp_v) begin
        n_fail++;
        $display("FAIL backpressure valid cycle %0d: got %b expected %b", c, result_valid_o, exp_v);
      end
      if (exp_v) begin
        n_checks++;
        if (result_o !== exp_r) begin
          n_fail++;
          $display("FAIL backpressure result cycle %0d: got %h expected %h", c, result_o, exp_r);
        end
      end
      if (c == 18) begin
        n_checks++;
        if (busy_o !== 1'b1) begin
          n_fail++;
          $display("FAIL backpressure busy while stalled: got %b expected 1", busy_o);
        end
      end
      @(posedge clk); #1;
    end
    result_ready_i = 1'b1;
    n_checks++;
    if ({a_ovf_o, b_ovf_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL backpressure ovf flags: got %b expected 00", {a_ovf_o, b_ovf_o});
    end
  endtask

  task automatic test_overflow_reset();
    apply_reset();
    // Three full pairs build a partial sum, then five A-only pulses overrun the A FIFO.
    for (int c = 0; c <= 8; c++) begin
      a_valid_i = (c <= 7);
      a_data_i  = 32'd100;
      b_valid_i = (c <= 2);
      b_data_i  = 32'd100;
      @(negedge clk);
      if (c == 7) begin
        n_checks++;
        if (a_ovf_o !== 1'b0) begin
          n_fail++;
          $display("FAIL overflow early a_ovf: got %b expected 0", a_ovf_o);
        end
      end
      if (c == 8) begin
        n_checks++;
        if ({a_ovf_o, b_ovf_o, busy_o} !== 3'b101) begin
          n_fail++;
          $display("FAIL overflow flags: got aovf=%b bovf=%b busy=%b expected 1 0 1",
                   a_ovf_o, b_ovf_o, busy_o);
        end
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_ovf_o, busy_o, result_valid_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL overflow after reset: got aovf=%b busy=%b valid=%b expected 0 0 0",
               a_ovf_o, busy_o, result_valid_o);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      a_vec[i] = 32'(i + 1);
      b_vec[i] = 32'd2;
    end
    run_stream("post-reset", 0, 0, 10, 64'd72);
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      a_vec[i] = 32'h7FFF_FFFF;
      b_vec[i] = 32'h7FFF_FFFF;
    end
`ifdef DOT_PRODUCT_SATURATE_EN
    run_stream("saturate", 0, 0, 10, 64'h7FFF_FFFF_FFFF_FFFF);
`else
    // 8*(2^31-1)^2 = 2^65 - 2^35 + 8, which wraps to -2^35 + 8.
    run_stream("wrap", 0, 0, 10, 64'hFFFF_FFF8_0000_0008);
`endif
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_skewed();
    test_signed();
    test_back_to_back();
    test_overflow_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dot_product_accumulator.md
Name: dot_product_accumulator

Overview:
- Sits directly downstream of two data_sequencer instances: the A-row stream and the B-column stream.
- Consumes their serial DATA_WIDTH-bit element streams and multiplies element pairs.
- Accumulates VECTOR_LEN products and presents one dot-product result per vector to the result writer over a valid/ready handshake.
- Small per-operand skew FIFOs absorb misalignment between the two streams, because the sequencers have no backpressure.

Parameters:
- DATA_WIDTH, 32: element width, signed two's complement. Equals the sequencer output width.
- VECTOR_LEN, 8: elements per dot product. Must be ≥2.
- ACC_WIDTH, 64: accumulator and result width. Must be ≥2*DATA_WIDTH.
- FIFO_DEPTH, 4: per-operand skew FIFO depth. Power of 2, ≥2.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- a_valid_i  input  1  A element valid. Driven by the A sequencer's valid_o.
- a_data_i  input  DATA_WIDTH  A element
- b_valid_i  input  1  B element valid
- b_data_i  input  DATA_WIDTH  B element
- result_o  output  ACC_WIDTH  dot-product result
- result_valid_o  output  1  result valid
- result_ready_i  input  1  downstream accepts result
- a_ovf_o  output  1  sticky: an A element was dropped on a full FIFO
- b_ovf_o  output  1  sticky: a B element was dropped on a full FIFO
- busy_o  output  1  any FIFO non-empty, or a product or partial sum in flight

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (port reset).
  - Sampled on the rising edge of clk only.
  - Overrides all other activity, including mid-vector: partial sums and FIFO contents are discarded.
- Reset values: result_o=0, result_valid_o=0, a_ovf_o=0, b_ovf_o=0, busy_o=0. Internally, FIFOs empty, element counter 0, product stage invalid, accumulator 0.
- FIFO push/pop rules:
  - A valid input is always pushed; there is no backpressure upstream.
  - Push and pop in the same cycle is legal, including when the FIFO is full: the count is unchanged and no data is lost.
  - Push on full without a same-cycle pop drops the element and sets that operand's ovf flag. The flag stays set until reset.
- Stall condition: the product stage holds the last element of a vector, and result_valid_o=1 with result_ready_i=0.
- Pop condition: both FIFOs non-empty and not stalled. A and B pop together.
- Stage 1 (product register): on pop, register the full-width signed product a*b (2*DATA_WIDTH bits). Also register a last flag, set when the element counter equals VECTOR_LEN-1.
  - The element counter wraps to 0 after the last element.
  - While stalled, stage 1 holds its contents.
- Stage 2 (accumulate, product valid and not stalled):
  - The product is sign-extended to ACC_WIDTH.
  - First element of a vector: acc = product. Otherwise acc = acc + product, wrapping modulo 2^ACC_WIDTH.
  - Last element: result_o is loaded with the final sum and result_valid_o is set on the same edge. The accumulator restarts with the next vector's first element.
- Result handshake:
  - result_o and result_valid_o are held stable while result_valid_o=1 and result_ready_i=0.
  - result_valid_o clears on an accept edge unless a new result loads on that same edge, in which case it stays 1 with new data. Back-to-back results are therefore possible.
- Latency and throughput:
  - An element pair whose later operand is presented in cycle N gives a product in N+2.
  - The last pair presented in cycle N gives result_valid_o=1 from cycle N+3.
  - Throughput is 1 element pair per cycle.
- busy_o is combinational: OR of FIFO non-empty, product valid, and accumulator mid-vector.

Optional Feature:
- Macro: DOT_PRODUCT_SATURATE_EN.
- Defined: each stage-2 add detects signed overflow. On overflow the accumulator clamps to 2^(ACC_WIDTH-1)-1 (positive overflow) or -2^(ACC_WIDTH-1) (negative overflow). Subsequent adds continue from the clamped value.
- Not defined: the add wraps modulo 2^ACC_WIDTH and no overflow logic is synthesized.

Test Plan:
1. Aligned streams, default parameters:
   - Stimulus: a=1..8 and b=2 (all elements) on cycles 0–7, with result_ready_i=1.
   - Response: result_o=72 with result_valid_o=1 for exactly one cycle, at cycle 10. busy_o=0 from cycle 11. Both ovf flags stay 0.
2. Skewed streams:
   - Stimulus: same data as test 1, with the b stream delayed 3 cycles (b on cycles 3–10).
   - Response: result_o=72 at cycle 13, no overflow flags.
3. Signed data:
   - Stimulus: a=-3 and b=5 for all 8 elements.
   - Response: result_o=-120, i.e. 0xFFFFFFFFFFFFFF88.
4. Backpressure:
   - Stimulus: two vectors back to back (results 72, then 36 with a=1..8, b=1), result_ready_i=0 until cycle 20.
   - Response: result_o=72 held stable through cycle 20, with the second vector's last product stalled in stage 1. After accept, result_o=36 with valid=1 on the next cycle. No overflow flags.
5. FIFO overflow and reset:
   - Stimulus: 5 a_valid_i pulses with b idle.
   - Response: a_ovf_o=1 after the 5th pulse, b_ovf_o=0. Asserting reset for 1 cycle clears a_ovf_o, busy_o and the FIFOs.
   - Follow-up: a full vector afterwards produces a correct result, proving the stale partial sum was discarded.
6. Saturation:
   - Stimulus: a=b=0x7FFFFFFF for all 8 elements.
   - Response with DOT_PRODUCT_SATURATE_EN defined: result_o=0x7FFFFFFFFFFFFFFF.
   - Response without the macro: the wrapped value, 8*(2^31-1)^2 mod 2^64 interpreted as signed.
